// File: rtl/mdu_pkg.sv
// Shared types and opcode helpers for the iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    // Signed variants take operand magnitudes and fix the result sign afterwards.
    function automatic logic OP_IS_SIGNED(input logic [2:0] op);
        return (op == MULT) || (op == DIV);
    endfunction

    function automatic logic OP_IS_DIV(input logic [2:0] op);
        return (op == DIV) || (op == DIVU);
    endfunction

    // Opcodes 0..3 run through the iterative datapath; 4..7 never enter the FSM.
    function automatic logic OP_IS_ITER(input logic [2:0] op);
        return !op[2];
    endfunction

endpackage

// File: rtl/mdu_cond_neg.sv
// Conditional two's-complement negation: y = neg ? -x : x.
module mdu_cond_neg #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y
);

    assign y = neg ? ((~x) + W'(1)) : x;

endmodule

// File: rtl/seq_mul_div.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One result bit per cycle; the first iteration is folded into the accepting
// edge so that W iterations fit in the IDLE->RUN->FIX->DONE sequence.
module seq_mul_div
    import mdu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int CNT_W = $clog2(W) + 1;

    mdu_state_e         state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2*W:0]       work;      // multiply: {acc, multiplier}; divide: {rem, quotient}
    logic [W-1:0]       opnd_q;    // multiplicand magnitude or divisor magnitude
    logic               is_div_q;
    logic               sgn_res_q;
    logic               sgn_a_q;
    logic               dz_q;

    logic               accept;
    logic               zero_div;
    logic [W-1:0]       mag_a, mag_b;
    logic [W-1:0]       opnd_nxt;
    logic [2*W:0]       work_init;
    logic [2*W-1:0]     prod_fix;
    logic [W-1:0]       quo_fix, rem_fix;

    // One multiply (shift-add) or divide (restoring subtract) iteration.
    function automatic logic [2*W:0] step(input logic [2*W:0] w,
                                          input logic [W-1:0] d,
                                          input logic         div);
        logic [W:0] sum;
        logic [W:0] rem_sh;
        logic [W:0] trial;
        if (div) begin
            rem_sh = w[2*W-1:W-1];
            trial  = rem_sh - {1'b0, d};
            if (!trial[W])
                return {trial, w[W-2:0], 1'b1};
            else
                return {rem_sh, w[W-2:0], 1'b0};
        end else begin
            sum = {1'b0, w[2*W-1:W]} + {1'b0, d};
            if (w[0])
                return {1'b0, sum, w[W-1:1]};
            else
                return {1'b0, w[2*W:1]};
        end
    endfunction

    assign accept   = start && (state == IDLE);
    assign zero_div = OP_IS_DIV(op) && (b == '0);
    assign busy     = (state != IDLE);

    mdu_cond_neg #(.W(W)) u_mag_a (
        .x   (a),
        .neg (OP_IS_SIGNED(op) && a[W-1]),
        .y   (mag_a)
    );

    mdu_cond_neg #(.W(W)) u_mag_b (
        .x   (b),
        .neg (OP_IS_SIGNED(op) && b[W-1]),
        .y   (mag_b)
    );

    mdu_cond_neg #(.W(2*W)) u_fix_prod (
        .x   (work[2*W-1:0]),
        .neg (sgn_res_q),
        .y   (prod_fix)
    );

    mdu_cond_neg #(.W(W)) u_fix_quo (
        .x   (work[W-1:0]),
        .neg (sgn_res_q),
        .y   (quo_fix)
    );

    mdu_cond_neg #(.W(W)) u_fix_rem (
        .x   (work[2*W-1:W]),
        .neg (sgn_a_q),
        .y   (rem_fix)
    );

    assign opnd_nxt  = OP_IS_DIV(op) ? mag_b : mag_a;
    assign work_init = {{(W+1){1'b0}}, (OP_IS_DIV(op) ? mag_a : mag_b)};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start && OP_IS_ITER(op)) state_nxt = zero_div ? DONE : RUN;
            RUN:  if (cnt == CNT_W'(2)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Working register, operand latch and sign bookkeeping.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start && OP_IS_ITER(op)) begin
                    is_div_q  <= OP_IS_DIV(op);
                    sgn_res_q <= OP_IS_SIGNED(op) && (a[W-1] ^ b[W-1]);
                    sgn_a_q   <= OP_IS_SIGNED(op) && a[W-1];
                    dz_q      <= zero_div;
                    opnd_q    <= opnd_nxt;
                    work      <= zero_div ? {1'b0, a, {W{1'b1}}}
                                          : step(work_init, opnd_nxt, OP_IS_DIV(op));
                end
            end
            RUN:  work <= step(work, opnd_q, is_div_q);
            FIX:  work <= {1'b0, (is_div_q ? {rem_fix, quo_fix} : prod_fix)};
            default: ;
        endcase
    end

    // Iteration counter, result registers and completion flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                if (op == MTHI) hi <= a;
                if (op == MTLO) lo <= a;
                if (OP_IS_ITER(op)) cnt <= CNT_W'(W);
            end else if (state == RUN) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (state == DONE) begin
                hi          <= work[2*W-1:W];
                lo          <= work[W-1:0];
                done        <= 1'b1;
                div_by_zero <= dz_q;
            end
        end
    end

endmodule

// File: tb/tb_seq_mul_div.sv
// Directed bench for seq_mul_div (W=16): vector table plus multi-cycle sequences.
module tb_seq_mul_div;

    localparam logic [2:0] C_MULT  = 3'd0;
    localparam logic [2:0] C_MULTU = 3'd1;
    localparam logic [2:0] C_DIV   = 3'd2;
    localparam logic [2:0] C_DIVU  = 3'd3;
    localparam logic [2:0] C_MTHI  = 3'd4;
    localparam logic [2:0] C_MTLO  = 3'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, div_by_zero;
    logic [15:0] hi, lo;

    int nchk = 0;
    int nfail = 0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] hi;
        logic [15:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    seq_mul_div #(.W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one op; returns the cycle number (cycle 1 follows the accepting edge)
    // in which done is first seen, and busy as seen in cycle 1.
    task automatic run_op(input logic [2:0] op_i, input logic [15:0] a_i,
                          input logic [15:0] b_i, output int lat, output logic busy1);
        @(negedge clk);
        start = 1'b1; op = op_i; a = a_i; b = b_i;
        @(posedge clk); #1;
        start = 1'b0;
        busy1 = busy;
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int          lat;
        logic        busy1;
        int          cyc;

        vecs[0]  = '{"multu_max",  C_MULTU, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 18};
        vecs[1]  = '{"mult_neg",   C_MULT,  16'hFFFD, 16'h0005, 16'hFFFF, 16'hFFF1, 1'b0, 18};
        vecs[2]  = '{"div_neg",    C_DIV,   16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0, 18};
        vecs[3]  = '{"div_ovf",    C_DIV,   16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 18};
        vecs[4]  = '{"divu_zero",  C_DIVU,  16'h0064, 16'h0000, 16'h0064, 16'hFFFF, 1'b1, 2};
        vecs[5]  = '{"divu_100_7", C_DIVU,  16'h0064, 16'h0007, 16'h0002, 16'h000E, 1'b0, 18};
        vecs[6]  = '{"mult_minsq", C_MULT,  16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0, 18};
        vecs[7]  = '{"div_negdiv", C_DIV,   16'h0007, 16'hFFFE, 16'h0001, 16'hFFFD, 1'b0, 18};
        vecs[8]  = '{"multu_sh",   C_MULTU, 16'h1234, 16'h0010, 16'h0001, 16'h2340, 1'b0, 18};
        vecs[9]  = '{"div_zero",   C_DIV,   16'hFF00, 16'h0000, 16'hFF00, 16'hFFFF, 1'b1, 2};
        vecs[10] = '{"mult_m1",    C_MULT,  16'h7FFF, 16'hFFFF, 16'hFFFF, 16'h8001, 1'b0, 18};

        // Reset state
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_dz",   {31'b0, div_by_zero}, 32'd0);
        check("rst_hi",   {16'b0, hi}, 32'd0);
        check("rst_lo",   {16'b0, lo}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Table-driven arithmetic vectors
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy1);
            check({vecs[i].name, "_busy1"}, {31'b0, busy1}, 32'd1);
            check({vecs[i].name, "_lat"},   lat, vecs[i].lat);
            check({vecs[i].name, "_hi"},    {16'b0, hi}, {16'b0, vecs[i].hi});
            check({vecs[i].name, "_lo"},    {16'b0, lo}, {16'b0, vecs[i].lo});
            check({vecs[i].name, "_dz"},    {31'b0, div_by_zero}, {31'b0, vecs[i].dz});
            check({vecs[i].name, "_busydone"}, {31'b0, busy}, 32'd0);
        end

        // Results and div_by_zero hold while idle
        repeat (3) @(posedge clk);
        #1;
        check("hold_hi",   {16'b0, hi}, 32'h0000FFFF);
        check("hold_lo",   {16'b0, lo}, 32'h00008001);
        check("hold_done", {31'b0, done}, 32'd0);
        run_op(C_DIVU, 16'h0005, 16'h0000, lat, busy1);
        repeat (4) @(posedge clk);
        #1;
        check("dz_hold", {31'b0, div_by_zero}, 32'd1);

        // MTHI then MTLO on consecutive edges, then a no-op opcode
        @(negedge clk);
        start = 1'b1; op = C_MTHI; a = 16'h1234;
        @(posedge clk); #1;
        check("mthi_hi",   {16'b0, hi}, 32'h00001234);
        check("mthi_busy", {31'b0, busy}, 32'd0);
        check("mthi_done", {31'b0, done}, 32'd0);
        op = C_MTLO; a = 16'hABCD;
        @(posedge clk); #1;
        check("mtlo_lo",   {16'b0, lo}, 32'h0000ABCD);
        check("mtlo_hi",   {16'b0, hi}, 32'h00001234);
        check("mtlo_busy", {31'b0, busy}, 32'd0);
        check("mtlo_done", {31'b0, done}, 32'd0);
        op = 3'd6; a = 16'h5555; b = 16'h0003;
        @(posedge clk); #1;
        op = 3'd7;
        @(posedge clk); #1;
        start = 1'b0;
        check("nop_hi",   {16'b0, hi}, 32'h00001234);
        check("nop_lo",   {16'b0, lo}, 32'h0000ABCD);
        check("nop_busy", {31'b0, busy}, 32'd0);
        check("nop_done", {31'b0, done}, 32'd0);

        // Start pulse while busy is ignored; op completes with original operands
        @(negedge clk);
        start = 1'b1; op = C_DIVU; a = 16'd100; b = 16'd7;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 5) begin @(posedge clk); #1; cyc++; end
        start = 1'b1; op = C_MULT; a = 16'h0003; b = 16'h0003;
        @(posedge clk); #1;
        start = 1'b0; cyc++;
        check("ign_busy", {31'b0, busy}, 32'd1);
        while (!done && cyc < 100) begin @(posedge clk); #1; cyc++; end
        check("ign_lat", cyc, 18);
        check("ign_hi",  {16'b0, hi}, 32'h00000002);
        check("ign_lo",  {16'b0, lo}, 32'h0000000E);

        // Reset mid-operation acts without a clock edge
        @(negedge clk);
        start = 1'b1; op = C_DIVU; a = 16'd100; b = 16'd7;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 5) begin @(posedge clk); #1; cyc++; end
        start = 1'b1; op = C_MULTU; a = 16'h0009; b = 16'h0009;
        @(posedge clk); #1;
        start = 1'b0; cyc++;
        while (cyc < 9) begin @(posedge clk); #1; cyc++; end
        check("pre_rst_busy", {31'b0, busy}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_hi",   {16'b0, hi}, 32'd0);
        check("arst_lo",   {16'b0, lo}, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_busy", {31'b0, busy}, 32'd0);
        run_op(C_DIVU, 16'd100, 16'd7, lat, busy1);
        check("fresh_lat", lat, 18);
        check("fresh_hi",  {16'b0, hi}, 32'h00000002);
        check("fresh_lo",  {16'b0, lo}, 32'h0000000E);
        check("fresh_dz",  {31'b0, div_by_zero}, 32'd0);

        @(posedge clk); #1;
        check("done_pulse", {31'b0, done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
